// File: rtl/freq_gen_measure.sv
// Frequency generate-and-measure block.
// frequency_module turns an input code into a 50%-duty square wave.
// frequency_counter measures the high time, low time and period of that
// wave in clock cycles. The top level connects the generator output
// straight into the counter input.

// Programmable square-wave generator. Each level lasts hp_reg cycles. A new
// input code is only picked up at a toggle, so the level in progress always
// runs to its full length.
module frequency_module #(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter real         LOW_FREQ   = 1_000.333,
    parameter int unsigned HIGH_FREQ  = 20_000_000,
    parameter int          INPUT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INPUT_BITS-1:0] input_value,
    output logic                  freq_out
);

    // Half-period bounds in clock cycles, rounded to the nearest cycle.
    // The fastest possible output is one toggle per cycle.
    localparam int HP_MAX     = $rtoi(real'(CLOCK_FREQ) / (2.0 * LOW_FREQ) + 0.5);
    localparam int HP_MIN_RAW = $rtoi(real'(CLOCK_FREQ) / (2.0 * real'(HIGH_FREQ)) + 0.5);
    localparam int HP_MIN     = (HP_MIN_RAW < 1) ? 1 : HP_MIN_RAW;

    // The span-times-code product needs 32+INPUT_BITS bits to avoid overflow.
    localparam int W = 32 + INPUT_BITS;
    localparam logic [W-1:0] HP_MAX_W  = W'(HP_MAX);
    localparam logic [W-1:0] SPAN_W    = W'(HP_MAX - HP_MIN);
    localparam logic [W-1:0] MAXCODE_W = W'((64'd1 << INPUT_BITS) - 64'd1);

    logic [W-1:0] hp_wide;
    logic [31:0]  hp_next;
    logic [31:0]  hp_reg;
    logic [31:0]  cnt;

    // Map the input code linearly onto the half-period range (truncating divide).
    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        hp_wide = HP_MAX_W - (SPAN_W * W'(input_value)) / MAXCODE_W;
        hp_next = 32'(hp_wide);
    end

    // Half-period counter: toggle the output and reload the length at the end of each level.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            freq_out <= 1'b0;
            cnt      <= '0;
            hp_reg   <= hp_next;
        end else if (cnt == hp_reg - 32'd1) begin
            freq_out <= ~freq_out;
            cnt      <= '0;
            hp_reg   <= hp_next;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// Frequency counter. The input is synchronised, edges are detected on the
// synchronised level, and each complete phase length is published. The
// partial phase in progress at reset is never published.
module frequency_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        freq_in,
    output logic [31:0] time_high,
    output logic [31:0] time_low,
    output logic [31:0] period
);

    logic        s1, s2, s3;
    logic        rise, fall;
    logic [31:0] pc;
    logic [31:0] hi_last;
    logic        seen_rise, seen_fall, hi_valid;
    logic [32:0] per_sum;
    logic [31:0] per_sat;

    // Edge detection on the synchronised level, plus a saturating period sum.
    always_comb begin
        rise    = s2 & ~s3;
        fall    = ~s2 & s3;
        per_sum = {1'b0, hi_last} + {1'b0, pc};
        per_sat = per_sum[32] ? 32'hFFFF_FFFF : per_sum[31:0];
    end

    // Two-flop synchroniser followed by one delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= freq_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Phase counter: restart at 1 on any edge, otherwise count up and stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            pc <= '0;
        else if (rise || fall)
            pc <= 32'd1;
        else if (pc != 32'hFFFF_FFFF)
            pc <= pc + 32'd1;
    end

    // Publish completed phases; a phase only counts once the opposite edge has been seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_rise <= 1'b0;
            seen_fall <= 1'b0;
            hi_valid  <= 1'b0;
            hi_last   <= '0;
            time_high <= '0;
            time_low  <= '0;
            period    <= '0;
        end else if (fall) begin
            seen_fall <= 1'b1;
            if (seen_rise) begin
                time_high <= pc;
                hi_last   <= pc;
                hi_valid  <= 1'b1;
            end
        end else if (rise) begin
            seen_rise <= 1'b1;
            if (seen_fall) begin
                time_low <= pc;
                if (hi_valid)
                    period <= per_sat;
            end
        end
    end

endmodule

// Top level: generator output looped back into the counter.
module freq_gen_measure #(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter real         LOW_FREQ   = 1_000.333,
    parameter int unsigned HIGH_FREQ  = 20_000_000,
    parameter int          INPUT_BITS = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [INPUT_BITS-1:0] INPUT_VALUE,
    output logic                  FREQ_OUT,
    output logic [31:0]           TIME_HIGH,
    output logic [31:0]           TIME_LOW,
    output logic [31:0]           PERIOD
);

    frequency_module #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .LOW_FREQ   (LOW_FREQ),
        .HIGH_FREQ  (HIGH_FREQ),
        .INPUT_BITS (INPUT_BITS)
    ) u_gen (
        .clk         (CLK),
        .rst         (RST),
        .input_value (INPUT_VALUE),
        .freq_out    (FREQ_OUT)
    );

    frequency_counter u_cnt (
        .clk       (CLK),
        .rst       (RST),
        .freq_in   (FREQ_OUT),
        .time_high (TIME_HIGH),
        .time_low  (TIME_LOW),
        .period    (PERIOD)
    );

endmodule

// File: tb/tb_freq_gen_measure.sv
// Testbench for freq_gen_measure.
// dut_a uses a faster LOW_FREQ (HP_MAX = 125) so full-range sweeps stay short.
// dut_b keeps the default parameters (HP_MAX = 24992) and is driven at high codes.
module tb_freq_gen_measure;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [7:0]  code_a, code_b;
    logic        fo_a, fo_b;
    logic [31:0] th_a, tl_a, per_a, th_b, tl_b, per_b;

    logic        sel = 1'b0;
    logic        fo;
    logic [31:0] th, tl, per;

    int cyc = 0;
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign fo  = sel ? fo_b  : fo_a;
    assign th  = sel ? th_b  : th_a;
    assign tl  = sel ? tl_b  : tl_a;
    assign per = sel ? per_b : per_a;

    freq_gen_measure #(
        .CLOCK_FREQ (50_000_000),
        .LOW_FREQ   (200_000.0),
        .HIGH_FREQ  (20_000_000),
        .INPUT_BITS (8)
    ) dut_a (
        .CLK         (clk),
        .RST         (rst_a),
        .INPUT_VALUE (code_a),
        .FREQ_OUT    (fo_a),
        .TIME_HIGH   (th_a),
        .TIME_LOW    (tl_a),
        .PERIOD      (per_a)
    );

    freq_gen_measure dut_b (
        .CLK         (clk),
        .RST         (rst_b),
        .INPUT_VALUE (code_b),
        .FREQ_OUT    (fo_b),
        .TIME_HIGH   (th_b),
        .TIME_LOW    (tl_b),
        .PERIOD      (per_b)
    );

    // Reference model: half-period straight from the rounding and linear-map rules.
    function automatic int round_pos(input real x);
        return $rtoi(x + 0.5);
    endfunction

    function automatic int hp_model(input real clock_hz, input real low_hz,
                                    input real high_hz, input int v);
        longint hmax, hmin;
        hmax = round_pos(clock_hz / (2.0 * low_hz));
        hmin = round_pos(clock_hz / (2.0 * high_hz));
        if (hmin < 1) hmin = 1;
        return int'(hmax - ((hmax - hmin) * longint'(v)) / 255);
    endfunction

    function automatic int hp_a(input int v);
        return hp_model(50.0e6, 200.0e3, 20.0e6, v);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Wait for the selected FREQ_OUT to change; report the cycle stamp of the change.
    task automatic wait_toggle(input int budget, output int at_cyc);
        logic p;
        bit   ok;
        p      = fo;
        ok     = 1'b0;
        at_cyc = cyc;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (fo !== p) begin
                ok     = 1'b1;
                at_cyc = cyc;
            end
        end
        if (!ok) begin
            total++;
            $display("FAIL toggle_timeout: no FREQ_OUT edge within %0d cycles", budget);
        end
    endtask

    // Apply a code, let it take over fully, measure one half-period and let outputs publish.
    task automatic settle(input int code, output int interval);
        int t, t1, t2;
        if (sel) code_b = 8'(code);
        else     code_a = 8'(code);
        repeat (4) wait_toggle(5000, t);
        wait_toggle(5000, t1);
        wait_toggle(5000, t2);
        interval = t2 - t1;
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        bit sel;
        int code;
        int th;
        int tl;
        int per;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int rel, t, t1, t2, iv, prev_per, v, exp_hp;

        vecs[0] = '{1'b0,   0,  125,  125,  250};
        vecs[1] = '{1'b0, 255,    1,    1,    2};
        vecs[2] = '{1'b0, 128,   63,   63,  126};
        vecs[3] = '{1'b0,  64,   94,   94,  188};
        vecs[4] = '{1'b1, 255,    1,    1,    2};
        vecs[5] = '{1'b1, 250,  492,  492,  984};
        vecs[6] = '{1'b1, 240, 1472, 1472, 2944};

        // Reset: everything held at zero.
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        code_a = 8'd0;
        code_b = 8'd255;
        repeat (10) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check($sformatf("reset_fo_%0d", s),  fo,  0);
            check($sformatf("reset_th_%0d", s),  th,  0);
            check($sformatf("reset_tl_%0d", s),  tl,  0);
            check($sformatf("reset_per_%0d", s), per, 0);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        rel   = cyc;

        // Code 0 after reset: first toggle a full HP_MAX after release.
        sel = 1'b0;
        wait_toggle(5000, t);
        check("first_toggle_a", t - rel, 125);

        // Table-driven steady-state codes.
        for (int i = 0; i < 7; i++) begin
            sel = vecs[i].sel;
            settle(vecs[i].code, iv);
            check($sformatf("vec%0d_halfper", i), iv,  vecs[i].th);
            check($sformatf("vec%0d_th", i),      th,  vecs[i].th);
            check($sformatf("vec%0d_tl", i),      tl,  vecs[i].tl);
            check($sformatf("vec%0d_per", i),     per, vecs[i].per);
        end

        // Sweep on dut_a: model values and non-increasing period.
        sel      = 1'b0;
        prev_per = 32'h7FFF_FFFF;
        for (int c = 0; c <= 255; c += 15) begin
            exp_hp = hp_a(c);
            settle(c, iv);
            check($sformatf("sweep%0d_th", c),  th,  exp_hp);
            check($sformatf("sweep%0d_per", c), per, 2 * exp_hp);
            check($sformatf("sweep%0d_mono", c), longint'(per <= 32'(prev_per)), 1);
            prev_per = int'(per);
        end

        // Random codes against the model.
        for (int r = 0; r < 12; r++) begin
            v      = int'($urandom_range(0, 255));
            exp_hp = hp_a(v);
            settle(v, iv);
            check($sformatf("rand%0d_c%0d_half", r, v), iv,  exp_hp);
            check($sformatf("rand%0d_c%0d_th", r, v),   th,  exp_hp);
            check($sformatf("rand%0d_c%0d_tl", r, v),   tl,  exp_hp);
            check($sformatf("rand%0d_c%0d_per", r, v),  per, 2 * exp_hp);
        end

        // Code change mid half-period: current level keeps its old length.
        sel = 1'b0;
        settle(0, iv);
        wait_toggle(5000, t);
        repeat (40) @(negedge clk);
        code_a = 8'd255;
        wait_toggle(5000, t1);
        check("midchange_old_len", t1 - t, 125);
        wait_toggle(5000, t2);
        check("midchange_new_len", t2 - t1, 1);

        // One-cycle reset mid-phase.
        settle(64, iv);
        check("prereset_th", th, 94);
        wait_toggle(5000, t);
        repeat (20) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        check("midreset_fo",  fo,  0);
        check("midreset_th",  th,  0);
        check("midreset_tl",  tl,  0);
        check("midreset_per", per, 0);
        rst_a = 1'b0;
        rel   = cyc;
        wait_toggle(5000, t);
        check("postreset_first_toggle", t - rel, 94);
        repeat (5) @(negedge clk);
        check("postreset_rise_th",  th,  0);
        check("postreset_rise_tl",  tl,  0);
        wait_toggle(5000, t1);
        repeat (5) @(negedge clk);
        check("postreset_fall_th",  th,  94);
        check("postreset_fall_per", per, 0);
        wait_toggle(5000, t2);
        repeat (5) @(negedge clk);
        check("postreset_rise2_tl",  tl,  94);
        check("postreset_rise2_per", per, 188);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
